// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds FSM states, grant owners and the starvation default.
package dmem_arb_pkg;

   localparam int STARVE_LIMIT_DEF = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACC_CPU = 2'd1,
      S_ACC_DBG = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_DBG = 1'b1;

   function automatic int cnt_width(input int lim);
      return (lim < 1) ? 1 : $clog2(lim + 1);
   endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating starvation counter for the debug port.
// Clear wins over increment; holds at LIMIT.
module dmem_arb_starve_ctr
   import dmem_arb_pkg::*;
#(
   parameter int LIMIT = STARVE_LIMIT_DEF,
   parameter int W     = cnt_width(LIMIT)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_at_lim
);

   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] r_cnt;

   // count contested CPU grants, reset on a debug grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != LIM)) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_at_lim = (r_cnt == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (CPU MEM stage / debug) onto one DATA_MEM.
// Grant in IDLE, one strobe cycle, one ack cycle, back to IDLE.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_wr,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ack,
   output logic        cpu_stall,
   input  logic        dbg_req,
   input  logic        dbg_wr,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic [31:0] dbg_rdata,
   output logic        dbg_ack,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   state_t      r_state;
   logic        r_own;
   logic        r_wr;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_cpu_rdata;
   logic [31:0] r_dbg_rdata;

   logic w_any;
   logic w_grant;
   logic w_gnt_dbg;
   logic w_inc;
   logic w_clr;
   logic w_at_lim;
   logic w_acc;
   logic w_resp;

   assign w_any     = cpu_req | dbg_req;
   assign w_grant   = (r_state == S_IDLE) & w_any;
   assign w_gnt_dbg = dbg_req & (~cpu_req | w_at_lim);
   assign w_clr     = w_grant & w_gnt_dbg;
   assign w_inc     = w_grant & ~w_gnt_dbg & dbg_req;
   assign w_acc     = (r_state == S_ACC_CPU) |
                      (r_state == S_ACC_DBG);
   assign w_resp    = (r_state == S_RESP);

   dmem_arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clr    (w_clr),
      .i_inc    (w_inc),
      .o_at_lim (w_at_lim)
   );

   // access sequencing: IDLE -> ACC_x -> RESP -> IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state <= w_gnt_dbg ? S_ACC_DBG : S_ACC_CPU;
               end
            end
            S_ACC_CPU, S_ACC_DBG: r_state <= S_RESP;
            S_RESP:               r_state <= S_IDLE;
            default:              r_state <= S_IDLE;
         endcase
      end
   end

   // latch the winner's request at grant time
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_own   <= GNT_CPU;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_grant) begin
         r_own   <= w_gnt_dbg ? GNT_DBG : GNT_CPU;
         r_wr    <= w_gnt_dbg ? dbg_wr : cpu_wr;
         r_addr  <= w_gnt_dbg ? dbg_addr : cpu_addr;
         r_wdata <= w_gnt_dbg ? dbg_wdata : cpu_wdata;
      end
   end

   // capture read data for the owner during the strobe cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpu_rdata <= '0;
         r_dbg_rdata <= '0;
      end else if (w_acc && !r_wr) begin
         if (r_own == GNT_DBG) begin
            r_dbg_rdata <= mem_rdata;
         end else begin
            r_cpu_rdata <= mem_rdata;
         end
      end
   end

   assign mem_rd    = w_acc & ~r_wr;
   assign mem_wr    = w_acc & r_wr;
   assign mem_addr  = w_acc ? r_addr : '0;
   assign mem_wdata = w_acc ? r_wdata : '0;

   assign cpu_ack   = w_resp & (r_own == GNT_CPU);
   assign dbg_ack   = w_resp & (r_own == GNT_DBG);
   assign cpu_stall = cpu_req & ~cpu_ack;
   assign cpu_rdata = r_cpu_rdata;
   assign dbg_rdata = r_dbg_rdata;

endmodule
